// File: rtl/pcc_pkg.sv
// Shared definitions for the pcc popcount-compare pipeline: vote FSM states
// and the count-width helper used wherever a 0..n count must be held.
package pcc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } vote_state_t;

    function automatic int PCC_CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pcc_vote_cnt.sv
// Per-sample vote counter: running count of ones, vote index, and the
// terminal-index flag that marks the last vote slot of a sample.
module pcc_vote_cnt
    import pcc_pkg::*;
#(
    parameter int NUM_VOTES = 16,
    parameter int CNT_W     = PCC_CNT_W(NUM_VOTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             vote,
    output logic [CNT_W-1:0] cnt,
    output logic             last_idx
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VOTES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    // clr is only asserted together with en, on the closing vote
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clr) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(vote);
            idx_d = idx_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign cnt      = cnt_q;
    assign last_idx = (idx_q == LAST);

endmodule

// File: rtl/pcc_vote_acc.sv
// Vote accumulator behind the pcc stage: counts ones per sample of NUM_VOTES
// votes and emits a registered threshold decision plus a length-mismatch flag.
module pcc_vote_acc
    import pcc_pkg::*;
#(
    parameter  int NUM_VOTES = 16,
    parameter  int THRESH    = 8,
    localparam int CNT_W     = PCC_CNT_W(NUM_VOTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_vote,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_class,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    localparam logic [CNT_W:0] THRESH_EXT = (CNT_W + 1)'(THRESH);

    vote_state_t      state_q, state_d;
    logic             class_q, class_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             accept;
    logic             close;
    logic             last_idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   sum;

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign close     = accept & (last_idx | in_last);
    // One extra bit so THRESH == NUM_VOTES compares without wrapping
    assign sum       = {1'b0, cnt} + (CNT_W + 1)'(in_vote);

    pcc_vote_cnt #(
        .NUM_VOTES (NUM_VOTES),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (accept),
        .clr      (close),
        .vote     (in_vote),
        .cnt      (cnt),
        .last_idx (last_idx)
    );

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            ACC: begin
                if (close) begin
                    count_d = sum[CNT_W-1:0];
                    class_d = (sum >= THRESH_EXT);
                    err_d   = in_last ^ last_idx;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            class_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign out_class = class_q;
    assign out_count = count_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_pcc_vote_acc.sv
// Self-checking bench for pcc_vote_acc: directed scenarios plus randomized
// valid/ready traffic against a per-sample popcount reference model.
module tb_pcc_vote_acc;

    localparam int NV = 16;
    localparam int TH = 8;
    localparam int CW = $clog2(NV + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_vote = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_class;
    logic [CW-1:0] out_count;
    logic          out_err;

    int errors = 0;
    int checks = 0;

    // Reference model: votes of the open sample and closed-sample results
    int m_cnt = 0;
    int m_n   = 0;
    int exp_cnt[$];
    bit exp_err[$];

    pcc_vote_acc #(
        .NUM_VOTES (NV),
        .THRESH    (TH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vote   (in_vote),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_n   = 0;
        exp_cnt.delete();
        exp_err.delete();
    endtask

    // A sample ends on in_last or on reaching NV votes, whichever is first
    task automatic model_accept(input bit v, input bit l);
        m_cnt += int'(v);
        m_n   += 1;
        if (l || m_n == NV) begin
            exp_cnt.push_back(m_cnt);
            exp_err.push_back(l != (m_n == NV));
            m_cnt = 0;
            m_n   = 0;
        end
    endtask

    // Presents n back-to-back votes from pat; last_at = 1-based vote carrying in_last (0 = none)
    task automatic feed(input logic [NV-1:0] pat, input int n, input int last_at, input string tag);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_accepting vote %0d: in_ready=%b out_valid=%b, want 1/0",
                         tag, i, in_ready, out_valid);
            end
            in_valid = 1'b1;
            in_vote  = pat[i];
            in_last  = (i + 1 == last_at);
            step();
        end
        in_valid = 1'b0;
        in_vote  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== 1'b0 ||
            out_count !== '0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b cls=%b cnt=%0d err=%b, want 1 0 0 0 0",
                     in_ready, out_valid, out_class, out_count, out_err);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_pattern();
        feed(16'h5555, 16, 16, "pattern");
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pattern_latency: vld=%b rdy=%b, want 1 0", out_valid, in_ready);
        end
        checks++;
        if (out_count !== CW'(8) || out_class !== 1'b1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL pattern_result: cnt=%0d cls=%b err=%b, want 8 1 0",
                     out_count, out_class, out_err);
        end
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pattern_release: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        feed(16'h007F, 16, 16, "stall");
        // Offer a one-vote sample while the result is held; it must wait
        in_valid = 1'b1;
        in_vote  = 1'b1;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== CW'(7) ||
                out_class !== 1'b0 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: vld=%b rdy=%b cnt=%0d cls=%b err=%b, want 1 0 7 0 0",
                         c, out_valid, in_ready, out_count, out_class, out_err);
            end
            step();
        end
        release_result();
        step();
        in_valid = 1'b0;
        in_vote  = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(1) || out_class !== 1'b0 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL stall_held_vote: vld=%b cnt=%0d cls=%b err=%b, want 1 1 0 1",
                     out_valid, out_count, out_class, out_err);
        end
        release_result();
    endtask

    task automatic test_early_last();
        feed(16'hFFFF, 5, 5, "early");
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(5) || out_class !== 1'b0 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL early_last: vld=%b cnt=%0d cls=%b err=%b, want 1 5 0 1",
                     out_valid, out_count, out_class, out_err);
        end
        release_result();
        feed(16'h0001, 16, 16, "early_next");
        checks++;
        if (out_count !== CW'(1) || out_class !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL early_next_sample: cnt=%0d cls=%b err=%b, want 1 0 0",
                     out_count, out_class, out_err);
        end
        release_result();
    endtask

    task automatic test_no_last();
        feed(16'hFFFF, 16, 0, "nolast");
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(16) || out_class !== 1'b1 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL no_last: vld=%b cnt=%0d cls=%b err=%b, want 1 16 1 1",
                     out_valid, out_count, out_class, out_err);
        end
        release_result();
        feed(16'h0003, 3, 3, "nolast_next");
        checks++;
        if (out_count !== CW'(2) || out_err !== 1'b1) begin
            errors++;
            $display("FAIL no_last_next_sample: cnt=%0d err=%b, want 2 1", out_count, out_err);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        feed(16'hFFFF, 9, 0, "rstmid");
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== '0) begin
            errors++;
            $display("FAIL reset_mid: vld=%b rdy=%b cnt=%0d, want 0 1 0", out_valid, in_ready, out_count);
        end
        rst = 1'b0;
        feed(16'h0000, 16, 16, "rstmid_next");
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(0) || out_class !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_next: vld=%b cnt=%0d cls=%b err=%b, want 1 0 0 0",
                     out_valid, out_count, out_class, out_err);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        bit votes[48];
        int vidx = 0;
        int nres = 0;
        int ec;
        bit ee;
        model_clear();
        for (int i = 0; i < 48; i++) votes[i] = 1'($urandom % 2);
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (c != 16 + 17 * nres) begin
                    errors++;
                    $display("FAIL b2b_timing: result %0d at cycle %0d, want %0d", nres, c, 16 + 17 * nres);
                end
                if (exp_cnt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b_unexpected: result at cycle %0d, none expected", c);
                end else begin
                    ec = exp_cnt.pop_front();
                    ee = exp_err.pop_front();
                    checks++;
                    if (out_count !== CW'(ec) || out_class !== (ec >= TH) || out_err !== ee) begin
                        errors++;
                        $display("FAIL b2b_result %0d: cnt=%0d cls=%b err=%b, want %0d %b %b",
                                 nres, out_count, out_class, out_err, ec, (ec >= TH), ee);
                    end
                end
                nres++;
            end
            if (vidx < 48) begin
                in_valid = 1'b1;
                in_vote  = votes[vidx];
                in_last  = ((vidx % 16) == 15);
                if (in_ready === 1'b1) begin
                    model_accept(in_vote, in_last);
                    vidx++;
                end
            end else begin
                in_valid = 1'b0;
                in_vote  = 1'b0;
                in_last  = 1'b0;
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (nres != 3) begin
            errors++;
            $display("FAIL b2b_count: results=%0d, want 3", nres);
        end
    endtask

    task automatic test_random();
        bit hold = 1'b0;
        int ec;
        bit ee;
        model_clear();
        for (int c = 0; c < 1000; c++) begin
            out_ready = (($urandom % 3) != 0);
            if (!hold) begin
                in_valid = (($urandom % 4) != 0);
                in_vote  = 1'($urandom % 2);
                in_last  = (($urandom % 10) == 0);
            end
            checks++;
            if (in_ready !== !out_valid) begin
                errors++;
                $display("FAIL rand_ready cycle %0d: rdy=%b vld=%b", c, in_ready, out_valid);
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_cnt.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected cycle %0d: cnt=%0d, none expected", c, out_count);
                end else begin
                    ec = exp_cnt.pop_front();
                    ee = exp_err.pop_front();
                    if (out_count !== CW'(ec) || out_class !== (ec >= TH) || out_err !== ee) begin
                        errors++;
                        $display("FAIL rand_result cycle %0d: cnt=%0d cls=%b err=%b, want %0d %b %b",
                                 c, out_count, out_class, out_err, ec, (ec >= TH), ee);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) model_accept(in_vote, in_last);
            hold = in_valid && (in_ready !== 1'b1);
            step();
        end
        in_valid  = 1'b0;
        in_vote   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_cnt.size() == 0) begin
                    errors++;
                    $display("FAIL rand_drain_unexpected: cnt=%0d", out_count);
                end else begin
                    ec = exp_cnt.pop_front();
                    ee = exp_err.pop_front();
                    if (out_count !== CW'(ec) || out_err !== ee) begin
                        errors++;
                        $display("FAIL rand_drain: cnt=%0d err=%b, want %0d %b", out_count, out_err, ec, ee);
                    end
                end
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (exp_cnt.size() != 0) begin
            errors++;
            $display("FAIL rand_missing: %0d results never delivered, want 0", exp_cnt.size());
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_stall();
        test_early_last();
        test_no_last();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcc_vote_acc.md
# pcc_vote_acc

Streaming vote accumulator that sits directly downstream of the `pcc` popcount-compare stage. It consumes one `outval` bit per evaluated neuron over a valid/ready handshake and counts the ones across a sample of `NUM_VOTES` votes. At the end of each sample it compares the vote count against a threshold and emits a registered class decision over a second valid/ready handshake. It also flags samples whose `in_last` marker does not match the expected vote count.

## Interface
- `NUM_VOTES`, default 16: votes per sample; legal range 2..255.
- `THRESH`, default 8: `out_class` = 1 when the vote count ≥ `THRESH`; legal range 0..`NUM_VOTES`.
- `CNT_W`, derived as `$clog2(NUM_VOTES+1)`: width of the count; not overridable.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `in_valid` input 1: `in_vote` is valid.
- `in_ready` output 1: the block can accept a vote.
- `in_vote` input 1: `outval` from `pcc`.
- `in_last` input 1: upstream marks the final vote of a sample.
- `out_valid` output 1: a result is held.
- `out_ready` input 1: the consumer accepts the result.
- `out_class` output 1: decision.
- `out_count` output `CNT_W`: vote count of the sample.
- `out_err` output 1: length mismatch in this sample.

## Operation
- FSM states: ACC, DONE.
  - ACC: `in_ready` = 1.
  - DONE: `in_ready` = 0, `out_valid` = 1.
- Accept: `in_valid & in_ready`.
  - Each accept increments `idx`.
  - Each accept adds `in_vote` to `cnt`.
- End of sample: an accept where `idx == NUM_VOTES-1` or `in_last == 1`, whichever comes first.
  - Latch `out_count` = `cnt + in_vote`.
  - Latch `out_class` = (`cnt + in_vote` ≥ `THRESH`).
  - Latch `out_err` = (`in_last` XOR (`idx == NUM_VOTES-1`)).
  - Clear `cnt` and `idx`, then go to DONE.
- DONE → ACC on `out_valid & out_ready`.
- Arithmetic:
  - `cnt` and `idx` are `CNT_W` bits, unsigned.
  - `cnt` ≤ `NUM_VOTES` by construction, so there is no saturation logic.
  - The comparison is unsigned and `CNT_W+1` bits wide to avoid overflow when `THRESH` = `NUM_VOTES`.
- Early `in_last`: the sample closes short, with `out_err` = 1 and the count of votes actually received.
- Missing `in_last` at vote `NUM_VOTES`: the sample closes, `out_err` = 1, and the next vote starts a new sample.
- `in_valid` while in DONE: not accepted; upstream must hold the vote (standard valid/ready).

## Timing
- Reset values:
  - State = ACC; `cnt` = 0; `idx` = 0.
  - `in_ready` = 1.
  - `out_valid` = 0, `out_class` = 0, `out_count` = 0, `out_err` = 0.
- Latency: `out_valid` rises the cycle after the closing accept.
- `in_ready` falls in that same cycle.
- Result outputs are registered and stable while `out_valid` = 1 and `out_ready` = 0.
- Throughput: one vote per cycle inside a sample, plus one bubble cycle per sample when `out_ready` is held high.
- `in_ready` is a pure function of state; it has no combinational path from `out_ready`.
- `rst` mid-sample or in DONE: the partial count and any pending result are discarded, and reset values take effect next cycle.
- `rst` has priority over all handshakes.

## Structure
- Shared package `pcc_pkg` holds:
  - the state enum `vote_state_t` {ACC, DONE};
  - a `PCC_CNT_W` function computing `$clog2(n+1)`, reused by the `pcc` count widths.
- One sub-module: `pcc_vote_cnt`. It contains `cnt` and `idx` registers with clear/enable and the terminal-index compare.
- The FSM and the output register stay in the top level.

## Test plan
- Reset, then 16 votes of pattern 1010…, `in_last` on vote 16 → `out_count` = 8, `out_class` = 1, `out_err` = 0, `out_valid` high one cycle after the final accept.
- 16 votes with seven 1s, correct `in_last` → `out_count` = 7, `out_class` = 0; hold `out_ready` = 0 for 5 cycles → outputs stable and `in_ready` = 0 throughout.
- `in_last` on vote 5 with all 1s → `out_count` = 5, `out_class` = 0, `out_err` = 1; the next sample starts from `cnt` = 0.
- 16 votes with no `in_last`, all 1s → `out_count` = 16, `out_class` = 1, `out_err` = 1.
- Assert `rst` after 9 votes → next cycle `out_valid` = 0 and `in_ready` = 1; a following full sample of all 0s gives `out_count` = 0.
- Back-to-back samples with `in_valid` and `out_ready` tied high → exactly one bubble cycle between samples and correct per-sample counts. Also check random valid/ready stalls against a reference popcount model.
